button_debounce: RTL and testbench

- Upstream conditioning stage for the Icestick button-driven counters (the LED counter that steps once per button press).
- Takes the raw active-low PMOD button pin, synchronises and debounces it, and produces a clean level plus single-cycle press, release and auto-repeat pulses.
- step_pulse is the single strobe that downstream counters consume.
- Runs at 12 MHz board clock; all timing is in clk cycles.

---
 rtl/icestick_defs.sv | 27 ++
 rtl/btn_sync.sv | 25 ++
 rtl/button_debounce.sv | 133 +++++++++++++
 tb/tb_button_debounce.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/icestick_defs.sv
// Board-wide constants for the Icestick button conditioning path.
// Clock rate, ms-to-cycle conversion and the debounce FSM state encoding.
package icestick_defs;

  localparam int unsigned CLK_HZ = 12000000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DB_10MS     = ms_to_cycles(10);
  localparam int unsigned HOLD_500MS  = ms_to_cycles(500);
  localparam int unsigned REPEAT_100MS = ms_to_cycles(100);

  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  typedef enum logic [1:0] {
    RELEASED   = ST_RELEASED,
    PRESS_DB   = ST_PRESS_DB,
    HELD       = ST_HELD,
    RELEASE_DB = ST_RELEASE_DB
  } db_state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous PMOD inputs.
// The reset value is an input so idle-high and idle-low pins share one block.
module btn_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= rst_val;
      q      <= rst_val;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces the active-low button pin into a clean level plus
// press / release / auto-repeat strobes; step_pulse drives the counters.
module button_debounce
  import icestick_defs::*;
#(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = int'(DB_10MS),
  parameter int HOLD_CYCLES     = int'(HOLD_500MS),
  parameter int REPEAT_CYCLES   = int'(REPEAT_100MS),
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic btn_sync_q;
  logic btn_s;

  btn_sync #(.W(1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (btn_n),
    .q       (btn_sync_q)
  );

  assign btn_s = ~btn_sync_q;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             first_q, first_d;
  logic             level_d, press_d, rel_d, rpt_d;
  logic [CNT_W-1:0] lim;

  // first_q selects the long initial hold before switching to repeat rate
  assign lim = first_q ? HOLD_LAST : REP_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RELEASED;
      db_q          <= '0;
      rep_q         <= '0;
      first_q       <= 1'b1;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      db_q          <= db_d;
      rep_q         <= rep_d;
      first_q       <= first_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      repeat_pulse  <= rpt_d;
      step_pulse    <= press_d | rpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rep_d   = rep_q;
    first_d = first_q;
    level_d = btn_level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = PRESS_DB;
          db_d    = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = RELEASED;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end else if (REPEAT_EN != 0) begin
          if (rep_q == lim) begin
            rpt_d   = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
          level_d = 1'b0;
          db_d    = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: two instances (repeat on/off) against a
// run-length reference model, with directed and random pin activity.
module tb_button_debounce;

  localparam int DB  = 4;
  localparam int HLD = 10;
  localparam int RPT = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;

  logic lvl0, prs0, rel0, rep0, stp0;
  logic lvl1, prs1, rel1, rep1, stp1;

  always #5 clk = ~clk;

  button_debounce #(
    .CNT_W(8), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HLD),
    .REPEAT_CYCLES(RPT), .REPEAT_EN(1)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0),
    .repeat_pulse(rep0), .step_pulse(stp0)
  );

  button_debounce #(
    .CNT_W(8), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HLD),
    .REPEAT_CYCLES(RPT), .REPEAT_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1),
    .repeat_pulse(rep1), .step_pulse(stp1)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: pin pipeline, stable-run length, active hold time
  logic m_p1 = 1'b1, m_p2 = 1'b1;
  logic m_lvl = 1'b0, m_prev = 1'b0;
  int   m_run = 0;
  int   m_act [2];
  int   m_lim [2];
  logic e_press, e_rel;
  logic e_rep [2];

  task automatic model(input logic pin, input logic r);
    logic s;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_rep[0] = 1'b0;
    e_rep[1] = 1'b0;
    if (r) begin
      m_p1 = 1'b1; m_p2 = 1'b1;
      m_lvl = 1'b0; m_prev = 1'b0; m_run = 0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_lim[k] = HLD;
      end
    end else begin
      s = ~m_p2;
      m_p2 = m_p1;
      m_p1 = pin;
      if (!m_lvl) begin
        if (s) begin
          m_run++;
          if (m_run == DB + 1) begin
            e_press = 1'b1; m_lvl = 1'b1; m_run = 0;
            for (int k = 0; k < 2; k++) begin
              m_act[k] = 0; m_lim[k] = HLD;
            end
          end
        end else m_run = 0;
      end else if (!s) begin
        m_run++;
        if (m_run == DB + 1) begin
          e_rel = 1'b1; m_lvl = 1'b0; m_run = 0;
        end
      end else begin
        m_run = 0;
        // only instance 0 has repeat enabled; re-entry edge is not counted
        if (m_prev) begin
          m_act[0]++;
          if (m_act[0] == m_lim[0]) begin
            e_rep[0] = 1'b1; m_act[0] = 0; m_lim[0] = RPT;
          end
        end
      end
      m_prev = s;
    end
  endtask

  task automatic step(input logic pin, input logic r, input string tag);
    logic [4:0] obs0, obs1, exp0, exp1;
    btn_n = pin;
    rst   = r;
    @(posedge clk);
    model(pin, r);
    #1;
    obs0 = {lvl0, prs0, rel0, rep0, stp0};
    obs1 = {lvl1, prs1, rel1, rep1, stp1};
    exp0 = {m_lvl, e_press, e_rel, e_rep[0], e_press | e_rep[0]};
    exp1 = {m_lvl, e_press, e_rel, e_rep[1], e_press | e_rep[1]};
    vectors++;
    assert (obs0 === exp0) else begin
      miscompares++;
      $error("FAIL %s rep_on observed %b expected %b", tag, obs0, exp0);
    end
    vectors++;
    assert (obs1 === exp1) else begin
      miscompares++;
      $error("FAIL %s rep_off observed %b expected %b", tag, obs1, exp1);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int first_press;
    int steps0, steps1, reps1, pulses;
    int len;
    logic pin;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "idle");

    // clean press held 40 edges: press at edge 6, repeats 16,21,26,31,36
    first_press = -1; steps0 = 0; steps1 = 0; reps1 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, "press_hold");
      if (prs0 && first_press < 0) first_press = i;
      steps0 += int'(stp0);
      steps1 += int'(stp1);
      reps1  += int'(rep1);
    end
    check_int("press_edge", first_press, 6);
    check_int("rep_on_steps", steps0, 6);
    check_int("rep_off_steps", steps1, 1);
    check_int("rep_off_repeats", reps1, 0);

    // release glitch while held, then real release
    pulses = 0;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, "glitch_hi");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, "glitch_lo");
      pulses += int'(rel0);
    end
    for (int i = 0; i < 2; i++) pulses += int'(rel0);
    check_int("glitch_no_release", pulses, 0);
    first_press = -1;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, "release");
      if (rel0 && first_press < 0) first_press = i;
    end
    check_int("release_edge", first_press, 6);
    check_int("release_level", int'(lvl0), 0);

    // bounce shorter than the debounce window
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "bounce_lo");
      pulses += int'(stp0) + int'(lvl0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, "bounce_hi");
      pulses += int'(stp0) + int'(lvl0) + int'(rel0);
    end
    check_int("bounce_quiet", pulses, 0);

    // reset asserted at edges 4 and 5 of a press
    first_press = -1;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, (i == 4 || i == 5), "rst_mid_press");
      if (prs0 && first_press < 0) first_press = i;
    end
    check_int("rst_press_edge", first_press, 12);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "rst_release");

    // random pin runs with occasional reset
    for (int n = 0; n < 60; n++) begin
      pin = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++)
        step(pin, ($urandom_range(0, 59) == 0), "random");
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
